// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state encoding and bus widths for the SPI burst sequencer
package spi_seq_pkg;
    localparam int SPI_ADDR_W = 8;
    localparam int SPI_DATA_W = 8;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo: synchronous FIFO with occupancy count and simultaneous push/pop
// Ports: push/push_data write side; pop/head/valid read side; count = occupancy.
module spi_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;
    // a pop frees a slot in the same cycle, so push into a full FIFO is legal when popping
    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    assign head    = mem[rp];
    assign valid   = count != '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= push_data;
endmodule

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: sequences multi-word SPI register bursts through a single-byte SPI driver
// Ports: start/op_read/start_addr/num_words/abort control; busy/done/error/words_done status;
// wr_* write byte stream in; rd_* read FIFO out; spi_* command/response to the SPI driver.
module spi_burst_sequencer
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ADDR_INCR      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        op_read,
    input  logic [SPI_ADDR_W-1:0]       start_addr,
    input  logic [7:0]                  num_words,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [7:0]                  words_done,
    input  logic [SPI_DATA_W-1:0]       wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic [SPI_DATA_W-1:0]       rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] rd_count,
    output logic                        spi_new_command,
    output logic [SPI_ADDR_W-1:0]       spi_register_addr,
    output logic [SPI_DATA_W-1:0]       spi_write_data,
    input  logic [SPI_DATA_W-1:0]       spi_data_read,
    input  logic                        spi_transaction_complete
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state, nstate;
    logic          op_q, tc_prev, comp_edge, timed_out, can_issue, last, push;
    logic [7:0]    num_q;
    logic [TW-1:0] tmo;
    assign comp_edge = spi_transaction_complete && !tc_prev;
    assign timed_out = tmo == TW'(TIMEOUT_CYCLES - 1);
    // one transaction in flight at most, so a free slot now guarantees room for its byte
    assign can_issue = !op_q || rd_count != CW'(FIFO_DEPTH);
    assign last      = words_done + 8'd1 == num_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (start) nstate = num_words == 8'd0 ? DONE : op_read ? ISSUE : FETCH;
            FETCH: nstate = abort ? DONE : wr_valid ? ISSUE : FETCH;
            ISSUE: nstate = abort ? DONE : can_issue ? WAIT : ISSUE;
            WAIT:  if (comp_edge) nstate = (last || abort) ? DONE : op_q ? ISSUE : FETCH;
                   else if (timed_out) nstate = DONE;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end
    always_comb begin
        busy            = state != IDLE;
        done            = state == DONE;
        wr_ready        = state == FETCH && !abort;
        spi_new_command = state == ISSUE && !abort && can_issue;
        push            = state == WAIT && comp_edge && op_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q              <= 1'b0;
            num_q             <= '0;
            tc_prev           <= 1'b0;
            tmo               <= '0;
            error             <= 1'b0;
            words_done        <= '0;
            spi_register_addr <= '0;
            spi_write_data    <= '0;
        end else begin
            tc_prev <= spi_transaction_complete;
            if (state == IDLE && start) begin
                op_q              <= op_read;
                num_q             <= num_words;
                spi_register_addr <= start_addr;
                error             <= 1'b0;
                words_done        <= '0;
            end
            if (wr_ready && wr_valid) spi_write_data <= wr_data;
            if (state == ISSUE) tmo <= '0;
            if (state == WAIT) begin
                tmo <= tmo + TW'(1);
                if (comp_edge) begin
                    words_done        <= words_done + 8'd1;
                    spi_register_addr <= spi_register_addr + SPI_ADDR_W'(ADDR_INCR);
                end else if (timed_out) error <= 1'b1;
            end
        end
    end
    spi_seq_fifo #(.WIDTH(SPI_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (spi_data_read),
        .pop       (rd_ready),
        .head      (rd_data),
        .valid     (rd_valid),
        .count     (rd_count)
    );
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb_spi_burst_sequencer: directed bench with SPI responder, FIFO queue model and strobe log
module tb_spi_burst_sequencer;
    localparam int T = 64;
    logic       clk = 0, rst, start, op_read, abort, wr_valid, rd_ready;
    logic       spi_transaction_complete;
    logic [7:0] start_addr, num_words, wr_data, spi_data_read;
    logic       busy, done, error, wr_ready, rd_valid, spi_new_command;
    logic [7:0] words_done, rd_data, spi_register_addr, spi_write_data;
    logic [4:0] rd_count;
    spi_burst_sequencer #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(T), .ADDR_INCR(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op_read(op_read), .start_addr(start_addr),
        .num_words(num_words), .abort(abort), .busy(busy), .done(done), .error(error),
        .words_done(words_done), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_count(rd_count),
        .spi_new_command(spi_new_command), .spi_register_addr(spi_register_addr),
        .spi_write_data(spi_write_data), .spi_data_read(spi_data_read),
        .spi_transaction_complete(spi_transaction_complete)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    int done_cnt = 0, wr_cnt = 0, cyc = 0, last_strobe_cyc = 0, last_done_cyc = 0;
    int d0, w0, start_cyc, pend = 0, hi = 0;
    bit hang = 0, cur_read = 0;
    logic prev_tc_m = 0, prev_cmd = 0;
    logic [7:0]  resp_addr;
    logic [7:0]  mq[$];
    logic [7:0]  pops[$];
    logic [15:0] sl[$];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    // SPI driver stand-in: answers addr^A5 twenty cycles after a strobe, completion held high 2 cycles
    initial begin
        spi_transaction_complete = 0;
        spi_data_read = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                pend = 0; hi = 0; spi_transaction_complete = 0;
            end else begin
                if (hi > 0) begin hi--; if (hi == 0) spi_transaction_complete = 0; end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin spi_data_read = resp_addr ^ 8'hA5; spi_transaction_complete = 1; hi = 2; end
                end
                if (spi_new_command && !hang) begin pend = 20; resp_addr = spi_register_addr; end
            end
        end
    end
    // expected FIFO contents: every completion edge of a read burst adds its byte, rd_ready removes the head
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            prev_tc_m = 0;
        end else begin
            if (rd_ready && mq.size() > 0) void'(mq.pop_front());
            if (cur_read && spi_transaction_complete && !prev_tc_m) mq.push_back(spi_data_read);
            prev_tc_m = spi_transaction_complete;
        end
    end
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("rd_count", 32'(rd_count), 32'(mq.size()));
            chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
            if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
            if (spi_new_command) begin
                chk("strobe_spacing", 32'(prev_cmd), 0);
                sl.push_back({spi_register_addr, spi_write_data});
                last_strobe_cyc = cyc;
            end
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (wr_ready && wr_valid) wr_cnt++;
            if (rd_valid && rd_ready) pops.push_back(rd_data);
            prev_cmd = spi_new_command;
        end
    end
    task automatic start_burst(input bit rd, input logic [7:0] a, input logic [7:0] n);
        sl.delete(); pops.delete();
        cur_read = rd; op_read = rd; start_addr = a; num_words = n; start = 1;
        d0 = done_cnt; w0 = wr_cnt; start_cyc = cyc + 1;
        tick();
        start = 0;
    endtask
    task automatic wait_done(input string n, input int budget);
        int i = 0;
        while (done_cnt == d0 && i < budget) begin tick(); i++; end
        chk({n, "_done_seen"}, 32'(done_cnt != d0), 1);
    endtask
    task automatic wait_strobes(input string n, input int k, input int budget);
        int i = 0;
        while (sl.size() < k && i < budget) begin tick(); i++; end
        chk({n, "_strobes_seen"}, 32'(sl.size() >= k), 1);
    endtask
    task automatic feed(input logic [7:0] b, input int gap);
        int k = 0;
        bit got = 0;
        wr_valid = 0;
        tick(gap);
        wr_valid = 1; wr_data = b;
        while (!got && k < 200) begin
            @(negedge clk); got = wr_ready;
            @(posedge clk); #1; k++;
        end
        wr_valid = 0;
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 1; start = 0; op_read = 0; abort = 0; wr_valid = 0; rd_ready = 0;
        start_addr = 0; num_words = 0; wr_data = 0;
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_cmd", 32'(spi_new_command), 0);
        chk("rst_words_done", 32'(words_done), 0);
        chk("rst_addr", 32'(spi_register_addr), 0);
        chk("rst_wdata", 32'(spi_write_data), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        rst = 0;
        tick(2);
        // read burst of 4 from 0x10
        start_burst(1, 8'h10, 8'd4);
        chk("rd4_busy", 32'(busy), 1);
        wait_done("rd4", 200);
        tick();
        chk("rd4_done_pulses", 32'(done_cnt - d0), 1);
        chk("rd4_done_low", 32'(done), 0);
        chk("rd4_busy_end", 32'(busy), 0);
        chk("rd4_words", 32'(words_done), 4);
        chk("rd4_nstrobes", 32'(sl.size()), 4);
        for (int i = 0; i < 4 && i < sl.size(); i++) chk("rd4_addr", 32'(sl[i][15:8]), 32'(8'h10 + i));
        chk("rd4_cnt", 32'(rd_count), 4);
        chk("rd4_head", 32'(rd_data), 32'h B5);
        if (mq.size() == 4) begin
            chk("rd4_m0", 32'(mq[0]), 32'hB5); chk("rd4_m1", 32'(mq[1]), 32'hB4);
            chk("rd4_m2", 32'(mq[2]), 32'hB7); chk("rd4_m3", 32'(mq[3]), 32'hB6);
        end else chk("rd4_model_size", 32'(mq.size()), 4);
        rd_ready = 1; tick(6); rd_ready = 0;
        chk("rd4_pops", 32'(pops.size()), 4);
        chk("rd4_drained", 32'(rd_count), 0);
        // write burst with address wrap and gaps in the byte stream
        start_burst(0, 8'hFE, 8'd3);
        fork
            begin feed(8'h01, 3); feed(8'h02, 5); feed(8'h03, 2); end
            wait_done("wr3", 300);
        join
        tick();
        chk("wr3_nstrobes", 32'(sl.size()), 3);
        if (sl.size() == 3) begin
            chk("wr3_s0", 32'(sl[0]), 32'hFE01);
            chk("wr3_s1", 32'(sl[1]), 32'hFF02);
            chk("wr3_s2", 32'(sl[2]), 32'h0003);
        end
        chk("wr3_handshakes", 32'(wr_cnt - w0), 3);
        chk("wr3_words", 32'(words_done), 3);
        chk("wr3_fifo_empty", 32'(rd_count), 0);
        // read burst of 20 into a 16-deep FIFO with no consumer, then drain
        start_burst(1, 8'h20, 8'd20);
        wait_strobes("rd20", 16, 600);
        tick(60);
        chk("rd20_stall_strobes", 32'(sl.size()), 16);
        chk("rd20_stall_busy", 32'(busy), 1);
        chk("rd20_stall_cnt", 32'(rd_count), 16);
        rd_ready = 1;
        wait_done("rd20", 400);
        tick(5);
        rd_ready = 0;
        chk("rd20_nstrobes", 32'(sl.size()), 20);
        chk("rd20_npops", 32'(pops.size()), 20);
        for (int i = 0; i < 20 && i < pops.size(); i++) chk("rd20_pop", 32'(pops[i]), 32'((8'h20 + i) ^ 8'hA5));
        chk("rd20_words", 32'(words_done), 20);
        // responder never completes: timeout
        hang = 1;
        start_burst(1, 8'h40, 8'd2);
        wait_done("tmo", T + 50);
        hang = 0;
        tick(3);
        chk("tmo_error", 32'(error), 1);
        chk("tmo_words", 32'(words_done), 0);
        chk("tmo_nstrobes", 32'(sl.size()), 1);
        chk("tmo_latency_ok", 32'(last_done_cyc - last_strobe_cyc >= T - 1 && last_done_cyc - last_strobe_cyc <= T + 1), 1);
        chk("tmo_fifo_empty", 32'(rd_count), 0);
        start_burst(1, 8'h50, 8'd1);
        chk("tmo_error_cleared", 32'(error), 0);
        wait_done("after_tmo", 100);
        tick();
        chk("after_tmo_words", 32'(words_done), 1);
        chk("after_tmo_error", 32'(error), 0);
        rd_ready = 1; tick(3); rd_ready = 0;
        // abort in WAIT of word 2 of 8
        rd_ready = 1;
        start_burst(1, 8'h60, 8'd8);
        wait_strobes("abort", 2, 100);
        abort = 1;
        wait_done("abort", 100);
        abort = 0;
        tick(30);
        rd_ready = 0;
        chk("abort_words", 32'(words_done), 2);
        chk("abort_nstrobes", 32'(sl.size()), 2);
        chk("abort_done_pulses", 32'(done_cnt - d0), 1);
        chk("abort_npops", 32'(pops.size()), 2);
        // abort while idle is ignored
        abort = 1; tick(2);
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_abort_done", 32'(done_cnt - d0), 1);
        abort = 0;
        // zero-length burst
        start_burst(1, 8'h33, 8'd0);
        tick(3);
        chk("zero_done_pulses", 32'(done_cnt - d0), 1);
        chk("zero_done_latency", 32'(last_done_cyc - start_cyc), 1);
        chk("zero_nstrobes", 32'(sl.size()), 0);
        chk("zero_busy", 32'(busy), 0);
        // asynchronous reset while in WAIT with data in the FIFO
        start_burst(1, 8'h70, 8'd3);
        wait_strobes("rst", 2, 100);
        tick(5);
        #2 rst = 1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cmd", 32'(spi_new_command), 0);
        chk("arst_rd_valid", 32'(rd_valid), 0);
        chk("arst_rd_count", 32'(rd_count), 0);
        tick(2);
        rst = 0;
        tick(2);
        start_burst(1, 8'h80, 8'd2);
        wait_done("post_rst", 100);
        tick();
        chk("post_rst_nstrobes", 32'(sl.size()), 2);
        if (sl.size() == 2) begin
            chk("post_rst_a0", 32'(sl[0][15:8]), 32'h80);
            chk("post_rst_a1", 32'(sl[1][15:8]), 32'h81);
        end
        chk("post_rst_words", 32'(words_done), 2);
        chk("post_rst_cnt", 32'(rd_count), 2);
        chk("post_rst_head", 32'(rd_data), 32'h25);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
